uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one `uart_tx` transmitter among `NumRequesters` byte-stream sources using round-robin arbitration. Arbitration is packet-level: a granted requester keeps the transmitter until it sends a byte flagged `req_last`, or until it stalls past a lock timeout. The block sits between on-chip message sources (telemetry, debug, command responses) and the `uart_tx` instance. It drives `uart_tx`'s `data`/`start` and watches its `ready`.

## Interface
- `NumRequesters`, 4: number of requesters; legal range 2..8.
- `LockTimeout`, 1024: consecutive stalled cycles before a packet lock is revoked; 0 disables the timeout; maximum 65535.
- `clk` in 1: system clock, same domain as `uart_tx`.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NumRequesters: requester i has a byte on offer.
- `req_data` in NumRequesters*8: byte of requester i at bits [8i+7:8i].
- `req_last` in NumRequesters: offered byte ends requester i's packet.
- `req_ready` out NumRequesters: combinational one-hot accept pulse; the byte is consumed when `req_valid[i] && req_ready[i]`.
- `tx_data` out 8: registered byte to `uart_tx.data`.
- `tx_start` out 1: registered 1-cycle pulse to `uart_tx.start`.
- `tx_ready` in 1: from `uart_tx.ready`.
- `grant_id` out $clog2(NumRequesters): current or most recent owner.
- `busy` out 1: high while any packet lock is held.
- `timeout` out 1: 1-cycle pulse when a lock is revoked.

## Operation
- State machine states: IDLE, SEND, ISSUE, HOLD.
- **IDLE**
  - If any `req_valid` is set, pick the winner round-robin, searching from `last_grant+1` upward and wrapping.
  - Register the winner into `grant_id`, set `busy`, clear the stall counter, go to SEND.
  - Otherwise stay in IDLE.
- **SEND**
  - If `tx_ready && req_valid[grant_id]`:
    - assert `req_ready[grant_id]` for this cycle;
    - register `tx_data <= req_data[grant_id]`;
    - latch `req_last[grant_id]` into `last_q`;
    - go to ISSUE.
  - Else if `req_valid[grant_id]` is low, increment the stall counter.
  - Otherwise clear the stall counter.
  - If `LockTimeout != 0` and the counter reaches `LockTimeout`:
    - pulse `timeout`, clear `busy`;
    - set `last_grant <= grant_id`;
    - go to IDLE.
- **ISSUE**
  - `tx_start = 1` for exactly this cycle; `uart_tx` samples it while its `ready` is still 1.
  - Go to HOLD.
- **HOLD**
  - `tx_ready` is ignored; it is low here because `uart_tx` drops `ready` the cycle after start.
  - If `last_q`: set `last_grant <= grant_id`, clear `busy`, go to IDLE.
  - Else go to SEND and clear the stall counter.
- **Fairness**
  - Other requesters are never granted while a lock is held, regardless of their `req_valid`.
  - No requester waits more than NumRequesters-1 packets.
- `req_ready` is zero in every state except the SEND accept cycle. Requesters must hold data stable while valid.

## Timing
- Reset values:
  - `tx_data` = 0, `tx_start` = 0, `req_ready` = 0, `grant_id` = 0, `busy` = 0, `timeout` = 0.
  - State IDLE, stall counter 0, `last_q` = 0.
  - `last_grant = NumRequesters-1`, so requester 0 has first priority.
- Grant latency: `req_valid` seen in IDLE at cycle t gives SEND at t+1. If `tx_ready` is high, accept happens at t+1 and `tx_start` at t+2.
- Byte accept at cycle t gives `tx_start` and `tx_data` valid at t+1. `tx_data` holds its value until the next accept.
- Back-to-back bytes are limited by `uart_tx` (160 sample periods). The minimum arbiter overhead is 3 cycles between accepts.
- `tx_ready` low in SEND: wait indefinitely with no timeout. The stall counter counts only requester stalls, not transmitter backpressure.
- Simultaneous `req_valid` from all requesters in IDLE: round-robin order only; no fixed priority beyond the pointer.
- Requester deasserts `req_valid` mid-packet: lock retained until `req_last` or timeout.
- `req_last` on the first byte: single-byte packet; release after HOLD.
- Stall counter width: 16 bits, saturating; compare uses `==`.
- Reset asserted mid-operation: all state clears immediately (asynchronous). A partially issued byte is dropped, and `uart_tx` is reset by the same domain.

## Structure
- Shared package `uart_pkg`:
  - `uart_arb_state_t` enum (IDLE, SEND, ISSUE, HOLD);
  - `UartSamplesPerBit = 16`;
  - `UartFrameBits = 10`.
- Sub-module `rr_arbiter`:
  - parameter `N`;
  - combinational inputs `req[N-1:0]` and `last_grant`;
  - outputs `found` and `winner`.
- The top-level FSM, registers and stall counter live in `uart_tx_arbiter`.

## Test plan
- **Single packet:** requester 2 offers 0x41, 0x42, 0x43 (last on 0x43) with `tx_ready` modelled by a real `uart_tx` -> three `tx_start` pulses carrying 0x41/0x42/0x43 in order; `busy` falls after the third HOLD; `grant_id` = 2.
- **Round-robin:** all four requesters valid with one-byte packets from reset -> grant order 0,1,2,3,0; each `req_ready` pulses exactly once per grant.
- **Packet lock:** requester 1 sends byte A, drops valid for 50 cycles, then sends B (last), while requester 0 stays valid -> `tx_data` sequence A, B, then requester 0; `timeout` stays 0.
- **Timeout:** `LockTimeout` = 8; requester 3 sends one non-last byte then stalls -> `timeout` pulses exactly 8 cycles after re-entering SEND; the next grant goes to requester 0.
- **Backpressure:** `tx_ready` forced low for 100 cycles in SEND with valid high -> no `req_ready`, no `tx_start`, no timeout; accept occurs on the cycle `tx_ready` rises.
- **Reset mid-packet:** assert `rst_n` = 0 during ISSUE -> all outputs 0 asynchronously. After release, requester 0 wins first even if requester 2 held the lock.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   uart_arb_state_t  : arbiter FSM states (IDLE, SEND, ISSUE, HOLD)
//   UartSamplesPerBit : oversampling ratio used by uart_tx
//   UartFrameBits     : start + 8 data + stop
//   UartByteCycles    : clocks uart_tx keeps ready low per byte
//   StallCntW         : width of the arbiter's requester-stall counter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    ISSUE = 2'd2,
    HOLD  = 2'd3
  } uart_arb_state_t;

  localparam int UartSamplesPerBit = 16;
  localparam int UartFrameBits     = 10;
  localparam int UartByteCycles    = UartSamplesPerBit * UartFrameBits;
  localparam int StallCntW         = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        in  N   request vector
//   last_grant in  W   previous winner; search starts at last_grant+1
//   found      out 1   at least one request set
//   winner     out W   first set request after last_grant, wrapping
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic         found,
  output logic [W-1:0] winner
);

  logic [W:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest set
  // request after last_grant is the one left standing.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = {1'b0, last_grant} + (W+1)'(k);
      if (idx >= (W+1)'(N)) idx = idx - (W+1)'(N);
      if (req[idx[W-1:0]]) begin
        found  = 1'b1;
        winner = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one uart_tx.
//   clk, rst_n   clock / async active-low reset
//   req_valid    in  N    requester i offers a byte
//   req_data     in  N*8  byte of requester i at [8i+7:8i]
//   req_last     in  N    offered byte closes requester i's packet
//   req_ready    out N    one-hot accept pulse (combinational)
//   tx_data      out 8    registered byte to uart_tx.data
//   tx_start     out 1    registered 1-cycle start pulse to uart_tx
//   tx_ready     in  1    uart_tx.ready
//   grant_id     out      current / most recent owner
//   busy         out 1    a packet lock is held
//   timeout      out 1    1-cycle pulse when a stalled lock is revoked
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NumRequesters = 4,
  parameter  int LockTimeout   = 1024,
  localparam int GW            = $clog2(NumRequesters)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NumRequesters-1:0]   req_valid,
  input  logic [NumRequesters*8-1:0] req_data,
  input  logic [NumRequesters-1:0]   req_last,
  output logic [NumRequesters-1:0]   req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_ready,
  output logic [GW-1:0]              grant_id,
  output logic                       busy,
  output logic                       timeout
);

  localparam bit                   TimeoutEn = (LockTimeout != 0);
  localparam logic [StallCntW-1:0] LockLimit = StallCntW'(LockTimeout);

  uart_arb_state_t      state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [StallCntW-1:0] stall_q, stall_d, stall_inc;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 busy_q, busy_d;
  logic                 last_q, last_d;
  logic                 tx_start_q, tx_start_d;
  logic                 timeout_q, timeout_d;

  logic                 arb_found;
  logic [GW-1:0]        arb_winner;
  logic                 cur_valid, cur_last, accept;
  logic [7:0]           cur_data;

  rr_arbiter #(.N(NumRequesters)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .found      (arb_found),
    .winner     (arb_winner)
  );

  // Owner's lane, selected by the registered grant.
  assign cur_valid = req_valid[grant_q];
  assign cur_last  = req_last[grant_q];
  assign cur_data  = req_data[{grant_q, 3'b000} +: 8];
  assign accept    = (state_q == SEND) && tx_ready && cur_valid;

  // Saturating so a long stall with the timeout disabled never wraps.
  assign stall_inc = (stall_q == '1) ? stall_q : stall_q + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    stall_d      = stall_q;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    last_d       = last_q;
    tx_start_d   = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_winner;
          busy_d  = 1'b1;
          stall_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          tx_data_d  = cur_data;
          last_d     = cur_last;
          tx_start_d = 1'b1;
          state_d    = ISSUE;
        end else begin
          // Only requester stalls count; transmitter backpressure with
          // valid held high resets the count instead.
          if (!cur_valid) stall_d = stall_inc;
          else            stall_d = '0;
          // Compare on the next value so the pulse lands exactly
          // LockTimeout cycles after SEND is entered.
          if (TimeoutEn && (stall_d == LockLimit)) begin
            timeout_d    = 1'b1;
            busy_d       = 1'b0;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      ISSUE: begin
        // tx_start_q is high during this cycle; uart_tx samples it here.
        state_d = HOLD;
      end
      HOLD: begin
        // uart_tx.ready is already low here, so it is not consulted.
        if (last_q) begin
          last_grant_d = grant_q;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else begin
          stall_d = '0;
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NumRequesters - 1);
      stall_q      <= '0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      last_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      last_q       <= last_d;
      tx_start_q   <= tx_start_d;
      timeout_q    <= timeout_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule
